// File: rtl/pad_cfg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pad_cfg_ctrl_pkg
// Purpose : Shared address map, sequencer state encoding and status packing
//           for the pad configuration controller.
// Revision: 1.0 - initial release
// ============================================================================
package pad_cfg_ctrl_pkg;

    localparam int CTRL_ADDR   = 'h40;
    localparam int STATUS_ADDR = 'h41;
    localparam int ACTIVE_BASE = 'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } pad_seq_state_e;

    // STATUS word layout: bit0 busy, bits[15:8] commit counter.
    function automatic logic [31:0] status_word(input logic busy, input logic [7:0] count);
        return {16'h0000, count, 7'h00, busy};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pad_cfg_ctrl
// Purpose : Shadow/active pad configuration registers with a paced commit
//           sequencer that copies shadow to active one pad at a time.
// Revision: 1.0 - initial release
// ============================================================================
module pad_cfg_ctrl
    import pad_cfg_ctrl_pkg::*;
#(
    parameter int N_PADS      = 48,
    parameter int CFG_W       = 6,
    parameter int STEP_CYCLES = 1,
    parameter int ADDR_W      = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [31:0]                   wdata_i,
    output logic                          gnt_o,
    output logic                          rvalid_o,
    output logic [31:0]                   rdata_o,
    output logic [N_PADS-1:0][CFG_W-1:0]  pad_cfg_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int IDX_W  = (N_PADS > 1) ? $clog2(N_PADS) : 1;
    localparam int STEP_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  C_LAST_IDX    = IDX_W'(N_PADS - 1);
    localparam logic [STEP_W-1:0] C_STEP_RELOAD = STEP_W'((STEP_CYCLES > 2) ? (STEP_CYCLES - 2) : 0);

    pad_seq_state_e                 r_state;
    logic [IDX_W-1:0]               r_idx;
    logic [STEP_W-1:0]              r_step;
    logic [7:0]                     r_count;
    logic [N_PADS-1:0][CFG_W-1:0]   r_shadow;
    logic [N_PADS-1:0][CFG_W-1:0]   r_active;
    logic [31:0]                    r_rdata;
    logic                           r_rvalid;

    logic [31:0]                    w_addr;
    logic                           w_is_shadow;
    logic                           w_is_active;
    logic                           w_is_status;
    logic                           w_is_ctrl;
    logic [IDX_W-1:0]               w_shadow_off;
    logic [IDX_W-1:0]               w_active_off;
    logic                           w_gnt;
    logic                           w_wr;
    logic                           w_rd;
    logic                           w_start;
    logic [31:0]                    w_rd_word;
    logic                           w_unused_wdata;

    assign w_addr       = 32'(addr_i);
    assign w_is_shadow  = (w_addr < 32'(N_PADS));
    assign w_is_active  = (w_addr >= 32'(ACTIVE_BASE)) && (w_addr < 32'(ACTIVE_BASE + N_PADS));
    assign w_is_status  = (w_addr == 32'(STATUS_ADDR));
    assign w_is_ctrl    = (w_addr == 32'(CTRL_ADDR));
    assign w_shadow_off = w_addr[IDX_W-1:0];
    assign w_active_off = IDX_W'(w_addr - 32'(ACTIVE_BASE));

    // Writes are held off for the whole commit so the committed image is the
    // shadow snapshot at the CTRL write; reads are never stalled.
    assign w_gnt   = req_i & (~we_i | (r_state == ST_IDLE));
    assign w_wr    = w_gnt & we_i;
    assign w_rd    = w_gnt & ~we_i;
    assign w_start = w_wr & w_is_ctrl & wdata_i[0];

    assign w_unused_wdata = ^wdata_i[31:CFG_W];

    always_comb begin
        w_rd_word = '0;
        if (w_is_shadow) begin
            w_rd_word = 32'(r_shadow[w_shadow_off]);
        end else if (w_is_active) begin
            w_rd_word = 32'(r_active[w_active_off]);
        end else if (w_is_status) begin
            w_rd_word = status_word(r_state != ST_IDLE, r_count);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_shadow <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_word;
            end
            if (w_wr && w_is_shadow) begin
                r_shadow[w_shadow_off] <= wdata_i[CFG_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_step   <= '0;
            r_count  <= '0;
            r_active <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_APPLY;
                        r_idx   <= '0;
                    end
                end
                ST_APPLY: begin
                    r_active[r_idx] <= r_shadow[r_idx];
                    if (r_idx == C_LAST_IDX) begin
                        r_state <= ST_DONE;
                    end else if (STEP_CYCLES == 1) begin
                        r_idx <= r_idx + 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                        r_step  <= C_STEP_RELOAD;
                    end
                end
                ST_WAIT: begin
                    if (r_step == '0) begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_APPLY;
                    end else begin
                        r_step <= r_step - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_count <= r_count + 8'd1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = w_gnt;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = r_rdata;
    assign pad_cfg_o = r_active;
    assign busy_o    = (r_state != ST_IDLE);
    assign done_o    = (r_state == ST_DONE);

endmodule
`default_nettype wire
